// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: Gray/binary conversion for
// pointers that cross clock domains.
package fifo_pkg;

  localparam int PTR_W_MAX = 32;

  typedef logic [PTR_W_MAX-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
    for (int i = PTR_W_MAX-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Two-flop synchronizer for a pointer entering the clk_i domain.
// Both stages clear asynchronously on rst_i low.
module ptr_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/read_ptr.sv
// FIFO read-side pointer, empty flag and occupancy.
// Define FIFO_GRAY_PTR_EN for Gray-coded cross-domain pointers.
module read_ptr
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_SIZE-1:0] wr_ptr_i,
  input  logic                 inc_i,
  output logic [ADDR_SIZE-1:0] ptr_o,
  output logic [ADDR_SIZE-1:0] addr_o,
  output logic                 fifo_empty_o,
  output logic                 rd_valid_o,
  output logic [ADDR_SIZE-1:0] level_o
);

  logic [ADDR_SIZE-1:0] wr_sync;
  logic [ADDR_SIZE-1:0] wr_bin;
  logic [ADDR_SIZE-1:0] rd_bin_q, rd_bin_d;
  logic [ADDR_SIZE-1:0] ptr_q, ptr_d;
  logic                 rd_valid_q;
  logic                 accept;

  ptr_sync #(
    .WIDTH (ADDR_SIZE)
  ) u_wr_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (wr_ptr_i),
    .q_o   (wr_sync)
  );

`ifdef FIFO_GRAY_PTR_EN
  assign wr_bin = ADDR_SIZE'(gray2bin(ptr_word_t'(wr_sync)));
  assign ptr_d  = ADDR_SIZE'(bin2gray(ptr_word_t'(rd_bin_d)));
`else
  assign wr_bin = wr_sync;
  assign ptr_d  = rd_bin_d;
`endif

  assign fifo_empty_o = (rd_bin_q == wr_bin);
  assign accept       = inc_i & ~fifo_empty_o;
  assign rd_bin_d     = rd_bin_q + ADDR_SIZE'(accept);

  // ptr_o is built from the next count so it never lags rd_bin
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_bin_q   <= '0;
      ptr_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_bin_q   <= rd_bin_d;
      ptr_q      <= ptr_d;
      rd_valid_q <= accept;
    end
  end

  assign addr_o     = rd_bin_q;
  assign ptr_o      = ptr_q;
  assign rd_valid_o = rd_valid_q;
  assign level_o    = wr_bin - rd_bin_q;

endmodule
